// File: rtl/result_word_serializer.sv
// Parallel-in, chunked-out unloader: emits one IN_WIDTH-bit word as CHUNK-bit pieces, MSB chunk first,
// over a valid/ready handshake. Define SER_PARITY_EN to add an even-parity bit alongside out_data.
module result_word_serializer #(
    parameter int IN_WIDTH = 160,
    parameter int CHUNK = 20,
    localparam int NUM_CHUNKS = IN_WIDTH / CHUNK,
    localparam int CW = $clog2(NUM_CHUNKS)
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [IN_WIDTH-1:0] load_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CHUNK-1:0]    out_data,
    output logic [CW-1:0]       chunk_idx,
    output logic                done
`ifdef SER_PARITY_EN
    ,
    output logic                out_parity
`endif
);

    generate
        if ((IN_WIDTH % CHUNK) != 0 || NUM_CHUNKS < 2) begin : g_bad_cfg
            $error("result_word_serializer: IN_WIDTH must be a multiple of CHUNK with at least two chunks");
        end
    endgenerate

    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CHUNKS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic                done_q, done_d;

    // Both handshakes are plain valid/ready: a beat moves on a rising edge where valid and ready
    // are both high; valid never depends on ready, and flush/rst override any beat in that cycle.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        if (flush) begin
            state_d = IDLE;
            shreg_d = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        shreg_d = load_data;
                        idx_d   = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        // Zero fill leaves shreg all-zero after the last chunk, so IDLE shows out_data=0.
                        shreg_d = shreg_q << CHUNK;
                        if (idx_q == LAST_IDX) begin
                            state_d = IDLE;
                            idx_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    shreg_d = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign load_ready = (state_q == IDLE);
    assign out_valid  = (state_q == SEND);
    assign out_data   = shreg_q[IN_WIDTH-1 -: CHUNK];
    assign chunk_idx  = idx_q;
    assign done       = done_q;

`ifdef SER_PARITY_EN
    assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_result_word_serializer.sv
// Bench for result_word_serializer: directed scenarios plus 1000 random words, checked by a
// negedge scoreboard that models the serializer as a queue of expected {chunk_idx, chunk} pairs.
module tb_result_word_serializer;

    localparam int IN_WIDTH = 160;
    localparam int CHUNK = 20;
    localparam int N = IN_WIDTH / CHUNK;
    localparam int CW = $clog2(N);
    localparam int W = CW + CHUNK;
    localparam int BUDGET = 400;

    logic                clock;
    logic                rst;
    logic                load_valid;
    logic                load_ready;
    logic [IN_WIDTH-1:0] load_data;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [CHUNK-1:0]    out_data;
    logic [CW-1:0]       chunk_idx;
    logic                done;
`ifdef SER_PARITY_EN
    logic                out_parity;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0]        exp_q[$];
    logic                exp_done = 1'b0;
    logic [IN_WIDTH-1:0] last_word = '0;
    logic [IN_WIDTH-1:0] collected = '0;

    result_word_serializer #(.IN_WIDTH(IN_WIDTH), .CHUNK(CHUNK)) dut (
        .clock      (clock),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .chunk_idx  (chunk_idx),
        .done       (done)
`ifdef SER_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [IN_WIDTH-1:0] act,
                         input logic [IN_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: word split into N chunks by plain shifts, MSB chunk first.
    task automatic push_word(input logic [IN_WIDTH-1:0] w);
        logic [IN_WIDTH-1:0] tmp;
        logic [CHUNK-1:0]    c;
        for (int i = 0; i < N; i++) begin
            tmp = w >> ((N - 1 - i) * CHUNK);
            c = tmp[CHUNK-1:0];
            exp_q.push_back({CW'(i), c});
        end
        last_word = w;
        collected = '0;
    endtask

    // Scoreboard / monitor: samples on the falling edge, away from the active edge.
    always @(negedge clock) begin
        logic busy;
        logic nxt_done;
        logic [W-1:0] item;
        busy = (exp_q.size() != 0);
        nxt_done = 1'b0;
        check("out_valid", IN_WIDTH'(out_valid), IN_WIDTH'(busy));
        check("load_ready", IN_WIDTH'(load_ready), IN_WIDTH'(!busy));
        check("done", IN_WIDTH'(done), IN_WIDTH'(exp_done));
        if (exp_done && done) check("loopback_word", collected, last_word);
        if (busy) begin
            check("out_data", IN_WIDTH'(out_data), IN_WIDTH'(exp_q[0][CHUNK-1:0]));
            check("chunk_idx", IN_WIDTH'(chunk_idx), IN_WIDTH'(exp_q[0][W-1:CHUNK]));
`ifdef SER_PARITY_EN
            check("out_parity", IN_WIDTH'(out_parity), IN_WIDTH'(^exp_q[0][CHUNK-1:0]));
`endif
        end else begin
            check("idle_out_data", IN_WIDTH'(out_data), '0);
            check("idle_chunk_idx", IN_WIDTH'(chunk_idx), '0);
`ifdef SER_PARITY_EN
            check("idle_out_parity", IN_WIDTH'(out_parity), '0);
`endif
        end
        if (busy && out_ready) begin
            item = exp_q.pop_front();
            collected = (collected << CHUNK) | IN_WIDTH'(item[CHUNK-1:0]);
            if (exp_q.size() == 0) nxt_done = 1'b1;
        end
        if (rst || flush) begin
            exp_q.delete();
            nxt_done = 1'b0;
        end else if (!busy && load_valid) begin
            push_word(load_data);
        end
        exp_done = nxt_done;
    end

    // driver tasks
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [IN_WIDTH-1:0] w);
        load_valid = 1'b1;
        load_data = w;
        cycle();
        load_valid = 1'b0;
    endtask

    task automatic run_until_done(input int stall_idx, input int stall_len, input bit rnd,
                                  output int n);
        int stall_left;
        stall_left = stall_len;
        n = 0;
        while (!done && n < BUDGET) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            else if (stall_left > 0 && out_valid && int'(chunk_idx) == stall_idx) begin
                out_ready = 1'b0;
                stall_left--;
            end else out_ready = 1'b1;
            cycle();
            n++;
        end
        out_ready = 1'b1;
        if (n >= BUDGET) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles", n);
        end
    endtask

    task automatic wait_idx(input int target);
        int k;
        k = 0;
        while (int'(chunk_idx) != target && k < BUDGET) begin
            cycle();
            k++;
        end
        if (k >= BUDGET) begin
            checks++;
            errors++;
            $display("FAIL idx_timeout: chunk_idx %0d never reached", target);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_data"}, IN_WIDTH'(out_data), '0);
        check({tag, "_chunk_idx"}, IN_WIDTH'(chunk_idx), '0);
        check({tag, "_done"}, IN_WIDTH'(done), '0);
        check({tag, "_load_ready"}, IN_WIDTH'(load_ready), IN_WIDTH'(1));
        check({tag, "_out_valid"}, IN_WIDTH'(out_valid), '0);
    endtask

    initial begin
        logic [IN_WIDTH-1:0] w1, w2, rw;
        int n;
        rst = 1'b1;
        load_valid = 1'b0;
        load_data = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        w1 = '0;
        for (int i = 0; i < N; i++) w1 = (w1 << CHUNK) | IN_WIDTH'(i + 1);
        w2 = '0;
        for (int i = 0; i < N; i++) w2 = (w2 << CHUNK) | IN_WIDTH'(20'hA0000 + 20'(i * 17));
        repeat (3) cycle();
        check_reset_outputs("reset");
        rst = 1'b0;
        cycle();

        // full-throughput word
        out_ready = 1'b1;
        load_word(w1);
        run_until_done(-1, 0, 1'b0, n);
        check("latency_full", IN_WIDTH'(n), IN_WIDTH'(N));
        check("done_load_ready", IN_WIDTH'(load_ready), IN_WIDTH'(1));
        cycle();

        // three-cycle stall while chunk index 2 is presented
        load_word(w1);
        run_until_done(2, 3, 1'b0, n);
        check("latency_stall", IN_WIDTH'(n), IN_WIDTH'(N + 3));
        cycle();

        // load during SEND ignored; second word taken in the done cycle
        load_word(w1);
        load_valid = 1'b1;
        load_data = w2;
        run_until_done(-1, 0, 1'b0, n);
        check("overlap_latency", IN_WIDTH'(n), IN_WIDTH'(N));
        check("overlap_load_ready", IN_WIDTH'(load_ready), IN_WIDTH'(1));
        cycle();
        load_valid = 1'b0;
        run_until_done(-1, 0, 1'b0, n);
        check("second_latency", IN_WIDTH'(n), IN_WIDTH'(N));
        cycle();

        // flush mid-word
        load_word(w1);
        wait_idx(4);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_out_valid", IN_WIDTH'(out_valid), '0);
        check("flush_out_data", IN_WIDTH'(out_data), '0);
        check("flush_done", IN_WIDTH'(done), '0);
        cycle();
        check("flush_done_after", IN_WIDTH'(done), '0);

        // reset mid-word
        load_word(w2);
        wait_idx(5);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_reset_outputs("midrst");
        cycle();

        // flush beats a simultaneous load
        load_valid = 1'b1;
        load_data = w1;
        flush = 1'b1;
        cycle();
        load_valid = 1'b0;
        flush = 1'b0;
        check("flush_load_out_valid", IN_WIDTH'(out_valid), '0);

        // flush beats the final transfer
        load_word(w1);
        wait_idx(N - 1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_last_done", IN_WIDTH'(done), '0);
        check("flush_last_out_valid", IN_WIDTH'(out_valid), '0);
        cycle();

`ifdef SER_PARITY_EN
        load_word(w1);
        out_ready = 1'b1;
        wait_idx(2);
        check("parity_chunk3", IN_WIDTH'(out_parity), '0);
        wait_idx(6);
        check("parity_chunk7", IN_WIDTH'(out_parity), IN_WIDTH'(1));
        run_until_done(-1, 0, 1'b0, n);
        cycle();
`endif

        // random words with random backpressure; loopback checked at each done
        for (int k = 0; k < 1000; k++) begin
            rw = '0;
            for (int j = 0; j < (IN_WIDTH + 31) / 32; j++) rw = (rw << 32) | IN_WIDTH'($urandom);
            load_word(rw);
            run_until_done(-1, 0, 1'b1, n);
            if ($urandom_range(0, 1) == 1) cycle();
        end
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
